serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//   Parallel-to-serial front end for the serial sequence detectors. Accepts a
//   DATA_W-bit word over a valid/ready handshake and emits it MSB-first, one bit
//   per enabled clock, on bit_out/bit_valid. This is the serial bit input of the
//   downstream Mealy detector. Back-to-back words stream with no idle gap.
// PARAMETERS
//   DATA_W    8   word width in bits; legal range >= 2
//   IDLE_BIT  0   value driven on bit_out whenever no bit is valid
// PORTS
//   clk        in   1       clock; rising edge
//   reset      in   1       asynchronous, active-low reset
//   in_data    in   DATA_W  word to serialize; sampled on handshake
//   in_valid   in   1       upstream word available
//   in_ready   out  1       feeder can accept a word this cycle
//   shift_en   in   1       downstream bit-consume enable (throttle)
//   bit_out    out  1       current serial bit
//   bit_valid  out  1       bit_out is being consumed this cycle
//   busy       out  1       a word is loaded and not yet fully shifted
//   word_done  out  1       1-cycle pulse coincident with the last consumed bit
// BEHAVIOUR
//   - Reset (reset=0): state IDLE, shift reg 0, bit counter 0.
//     Reset outputs: bit_valid=0, word_done=0, busy=0, bit_out=IDLE_BIT, in_ready=1.
//     A handshake while reset=0 is ignored.
//   - FSM states IDLE and SHIFT.
//     IDLE: in_ready=1. On in_valid=1: load shift reg <= in_data, cnt <= NBITS-1,
//     and go to SHIFT.
//     SHIFT: busy=1; bit_out=sreg[MSB]; bit_valid=shift_en.
//   - Per consumed bit (SHIFT and shift_en=1): sreg shifts left (0 fills the LSB)
//     and cnt decrements.
//     When cnt==0: word_done=1 (combinational, same cycle), in_ready=1.
//       If in_valid=1: load the next word and stay in SHIFT (zero-gap streaming).
//       Otherwise go to IDLE.
//   - In SHIFT with cnt!=0, or with shift_en=0: in_ready=0 and in_data is ignored.
//     With shift_en=0, sreg, cnt and bit_out hold; bit_valid=0 and word_done=0.
//   - Latency: word accepted at edge N; its first bit is valid in cycle N+1.
//     With shift_en held at 1, the last bit appears in cycle N+NBITS.
//   - NBITS = DATA_W (parity off) or DATA_W+1 (parity on).
//     cnt width is $clog2(NBITS+1). The counter never wraps: its 0 state is
//     terminal for the word.
//   - bit_out = IDLE_BIT whenever state==IDLE.
//   - Reset mid-word: the word is discarded and outputs drop to reset values
//     immediately (async). No word_done is issued for the aborted word.
//   - All state is updated on the clk rising edge only. There is no combinational
//     path from in_data to bit_out.
// CONFIGURATION
//   SER_PARITY_EN defined:
//     One extra bit follows the DATA_W data bits: the even parity bit (^in_data),
//     latched at load. word_done asserts on the parity bit, and NBITS=DATA_W+1.
//   SER_PARITY_EN undefined:
//     Only data bits are emitted, NBITS=DATA_W. No parity logic is synthesized.
// TESTING
//   1. Reset, then load 8'hA5 with shift_en=1 continuously
//      -> bit_out 1,0,1,0,0,1,0,1 in cycles N+1..N+8; word_done and in_ready
//         both high in N+8 only.
//   2. in_valid held with 8'h0A, then 8'hF0 loaded on the last-bit cycle
//      -> 16 contiguous bit_valid cycles 0000_1010_1111_0000, no gap;
//         word_done in cycles 8 and 16.
//   3. 8'h0A with shift_en alternating 1/0
//      -> same 8-bit sequence; bit_valid=0 and outputs held on shift_en=0 cycles;
//         word_done in cycle 15.
//   4. Drive reset=0 after the 3rd bit of 8'hFF
//      -> bit_valid=0 and busy=0 immediately, no word_done; after release
//         in_ready=1 and the next word starts cleanly.
//   5. in_valid=1 with 8'h33 while mid-word (cnt!=0)
//      -> in_ready=0 and the word is not taken; it is accepted on the last-bit
//         cycle of the current word.
//   6. SER_PARITY_EN: 8'h0A -> 9 bits, 9th bit 0; 8'h07 -> 9th bit 1;
//      word_done on the 9th bit in both cases.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Parallel-to-serial front end. It accepts a DATA_W-bit word over a
//   valid/ready handshake and emits it MSB first, one bit per enabled clock.
//   Back-to-back words stream with no idle gap: the next word can load on the
//   cycle that consumes the last bit of the current word.
//
// Build option:
//   SER_PARITY_EN - when defined, the even parity bit (^in_data) is appended
//                   after the data bits, so a word is DATA_W+1 bits long.
//                   When undefined, no parity logic is built.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   in_data    word to serialize, sampled on handshake
//   in_valid   upstream word available
//   in_ready   feeder can accept a word this cycle
//   shift_en   downstream bit-consume enable (throttle)
//   bit_out    current serial bit (IDLE_BIT when idle)
//   bit_valid  bit_out is being consumed this cycle
//   busy       a word is loaded and not yet fully shifted
//   word_done  1-cycle pulse coincident with the last consumed bit

module serial_bit_feeder #(
    parameter int unsigned DATA_W   = 8,
    parameter bit          IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              shift_en,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              word_done
);

`ifdef SER_PARITY_EN
    localparam int unsigned NBITS = DATA_W + 1;
`else
    localparam int unsigned NBITS = DATA_W;
`endif
    localparam int unsigned CNT_W = $clog2(NBITS + 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e             state;
    logic [NBITS-1:0]   sreg;
    logic [CNT_W-1:0]   cnt;

    logic [NBITS-1:0]   load_word;
    logic               last_bit;
    logic               accept;

`ifdef SER_PARITY_EN
    assign load_word = {in_data, ^in_data};
`else
    assign load_word = in_data;
`endif

    // Outputs decode straight from state so an async reset drops them at once.
    always_comb begin
        busy      = (state == StShift);
        bit_valid = busy && shift_en;
        last_bit  = bit_valid && (cnt == '0);
        word_done = last_bit;
        in_ready  = (state == StIdle) || last_bit;
        accept    = in_valid && in_ready;
        bit_out   = busy ? sreg[NBITS-1] : IDLE_BIT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= StIdle;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            if (accept) begin
                // Covers both the idle load and the zero-gap reload on the last bit.
                state <= StShift;
                sreg  <= load_word;
                cnt   <= CNT_W'(NBITS - 1);
            end else if (bit_valid) begin
                sreg <= {sreg[NBITS-2:0], 1'b0};
                if (cnt == '0) begin
                    // Counter zero is terminal for the word; it is never decremented.
                    state <= StIdle;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

    localparam int unsigned DATA_W   = 8;
    localparam bit          IDLE_BIT = 1'b0;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              shift_en = 1'b0;
    logic              bit_out;
    logic              bit_valid;
    logic              busy;
    logic              word_done;

    int checks = 0;
    int failures = 0;
    int wd_seen = 0;
    int bv_seen = 0;

    // Reference: the bits still to be emitted for the current word, in order.
    bit q[$];

    serial_bit_feeder #(
        .DATA_W   (DATA_W),
        .IDLE_BIT (IDLE_BIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        for (int i = DATA_W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SER_PARITY_EN
        q.push_back(^d);
`endif
    endtask

    // Called just after a rising edge; applies inputs, checks mid-cycle, steps model.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic se);
        logic e_busy, e_bv, e_bo, e_wd, e_rdy;
        in_valid = v;
        in_data  = d;
        shift_en = se;
        @(negedge clk);
        e_busy = (q.size() > 0);
        e_bv   = e_busy && se;
        e_bo   = e_busy ? q[0] : IDLE_BIT;
        e_wd   = e_bv && (q.size() == 1);
        e_rdy  = !e_busy || e_wd;
        check("busy", 32'(busy), 32'(e_busy));
        check("bit_valid", 32'(bit_valid), 32'(e_bv));
        check("bit_out", 32'(bit_out), 32'(e_bo));
        check("word_done", 32'(word_done), 32'(e_wd));
        check("in_ready", 32'(in_ready), 32'(e_rdy));
        if (word_done) wd_seen++;
        if (bit_valid) bv_seen++;
        @(posedge clk);
        if (e_bv) void'(q.pop_front());
        if (v && e_rdy) push_word(d);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        // Reset with a handshake offered; it must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hC3;
        shift_en = 1'b1;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_word_done", 32'(word_done), 32'd0);
        check("rst_bit_out", 32'(bit_out), 32'(IDLE_BIT));
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;

        // 1: single word, continuous shift_en.
        wd_seen = 0;
        bv_seen = 0;
        cycle(1'b1, 8'hA5, 1'b1);
        idle_cycles(12);
        check("t1_word_done_count", 32'(wd_seen), 32'd1);
`ifdef SER_PARITY_EN
        check("t1_bits", 32'(bv_seen), 32'd9);
`else
        check("t1_bits", 32'(bv_seen), 32'd8);
`endif

        // 2: in_valid held; second word taken on the last-bit cycle.
        wd_seen = 0;
        bv_seen = 0;
        cycle(1'b1, 8'h0A, 1'b1);
        for (int i = 1; i < DATA_W; i++) cycle(1'b1, 8'h0A, 1'b1);
`ifdef SER_PARITY_EN
        cycle(1'b1, 8'h0A, 1'b1);
`endif
        cycle(1'b1, 8'hF0, 1'b1);
        idle_cycles(12);
        check("t2_word_done_count", 32'(wd_seen), 32'd2);

        // 3: throttled by alternating shift_en.
        wd_seen = 0;
        cycle(1'b1, 8'h0A, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, (i % 2) == 0);
        idle_cycles(2);
        check("t3_word_done_count", 32'(wd_seen), 32'd1);

        // 4: async reset after the third bit of 8'hFF.
        wd_seen = 0;
        cycle(1'b1, 8'hFF, 1'b1);
        idle_cycles(3);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_bit_valid", 32'(bit_valid), 32'd0);
        check("t4_word_done", 32'(word_done), 32'd0);
        check("t4_bit_out", 32'(bit_out), 32'(IDLE_BIT));
        check("t4_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("t4_word_done_count", 32'(wd_seen), 32'd0);
        cycle(1'b1, 8'h96, 1'b1);
        idle_cycles(12);

        // 5: word offered mid-word is held off until the last-bit cycle.
        cycle(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 2 * DATA_W + 4; i++) cycle(1'b1, 8'h33, 1'b1);
        idle_cycles(12);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), DATA_W'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle_cycles(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
